midi_note_receiver: RTL
=======================

// Module: midi_note_receiver
// PURPOSE
//  Serial MIDI input front end: deserialises the 31.25 kbaud MIDI stream and decodes
//  Note On / Note Off for one selected channel. Outputs note number (MIDI_freq) and
//  velocity (volume) in the 7-bit form the square-wave voice consumes, plus a gate.
//  Single voice, last-note priority; sits between the board's MIDI opto input and the voice.
// PARAMETERS
//  CLK_HZ        50_000_000  system clock frequency
//  BAUD          31_250      MIDI bit rate
//  CLKS_PER_BIT  CLK_HZ/BAUD clocks per bit (1600 at defaults); derived, not overridden
// PORTS
//  clk           in   1  system clock, 50 MHz
//  reset         in   1  asynchronous, active-high reset
//  midi_rx       in   1  raw serial MIDI line, idle high, async to clk
//  channel       in   4  MIDI channel to accept (0..15); quasi-static
//  MIDI_freq     out  7  current note number
//  volume        out  7  current note velocity
//  gate          out  1  1 while the current note is held
//  note_valid    out  1  1-clk pulse when MIDI_freq/volume take a new Note On
//  framing_error out  1  1-clk pulse when a stop bit samples low
// BEHAVIOUR
//  Reset: MIDI_freq=69, volume=0, gate=0, note_valid=0, framing_error=0; sync FFs=1;
//   both FSMs idle, running status cleared. Reset mid-byte/mid-message discards all.
//  Input: 2-FF synchroniser on midi_rx; all logic uses the synchronised bit.
//  RX FSM (IDLE,START,DATA,STOP,WAIT_HIGH):
//   IDLE: falling edge -> START, counter=CLKS_PER_BIT/2-1.
//   START: at count 0 sample; low -> DATA (8 bits); high -> IDLE (glitch, no error).
//   DATA: sample every CLKS_PER_BIT at bit centre, LSB first; after bit 7 -> STOP.
//   STOP: at centre, high -> byte_valid 1 clk, IDLE; low -> framing_error 1 clk,
//    byte dropped, WAIT_HIGH. WAIT_HIGH: stay until line is high, then IDLE.
//  Parser FSM (WAIT_STATUS,WAIT_D1,WAIT_D2), acts only on byte_valid:
//   0xF8-0xFF (realtime): ignored, state and running status untouched.
//   0xF0-0xF7: clear running status -> WAIT_STATUS.
//   0x80-0xEF: running status=byte; accepted only if hi nibble 8/9 and lo nibble ==
//    channel, else running status marked ignore; -> WAIT_D1.
//   Data (bit7=0): WAIT_STATUS or ignore status -> dropped; WAIT_D1 -> latch d1,
//    WAIT_D2; WAIT_D2 -> execute, back to WAIT_D1 (running status kept).
//   Execute Note On, vel>0: MIDI_freq=d1, volume=vel, gate=1, note_valid=1.
//   Execute Note Off, or Note On vel=0: if d1==MIDI_freq, gate=0; else no change.
//    MIDI_freq/volume hold their values on note off.
//  Latency: outputs and note_valid update 1 clk after byte_valid of the final data
//   byte (i.e. 2 clks after that byte's stop-bit centre sample).
//  channel changes take effect on the next status byte.
// STRUCTURE
//  Package midi_pkg: NOTE_OFF=4'h8, NOTE_ON=4'h9, SYSRT_MIN=8'hF8, rx and parser
//   state enums, function clks_per_bit(clk_hz,baud).
//  Sub-module midi_uart_rx (sync + RX FSM; outputs byte, byte_valid, framing_error);
//   parser and output registers live in this module.
// TESTING
//  Bytes 0x90,0x3C,0x64, channel=0 -> MIDI_freq=60, volume=100, gate=1, one note_valid.
//  Then 0x40,0x50 (running status) -> MIDI_freq=64, volume=80, second note_valid.
//  0x80,0x3C,0x00 while note=64 -> gate stays 1; 0x90,0x40,0x00 -> gate=0, note holds 64.
//  0x91,0x3C,0x64 with channel=0 -> no output change; channel=1 -> note 60 accepted.
//  0x90,0x3C,0xF8,0x64 (realtime mid-message) -> note 60 / vel 100 accepted normally.
//  Stop bit forced low -> framing_error pulse, no byte; reset asserted mid-byte ->
//   outputs at reset values; next clean message decodes correctly.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared constants, state encodings and baud-rate helper for the MIDI note receiver.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [7:0] SYSRT_MIN  = 8'hF8;
  localparam logic [7:0] SYSCOM_MIN = 8'hF0;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    P_WAIT_STATUS,
    P_WAIT_D1,
    P_WAIT_D2
  } parser_state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI serial deserialiser: 2-FF input synchroniser plus start/data/stop bit FSM.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      state         <= RX_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      rx_byte       <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_meta       <= midi_rx;
      rx_sync       <= rx_meta;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        RX_IDLE: begin
          // Line is known high on entry, so a low sample marks the start edge.
          if (!rx_sync) begin
            state <= RX_START;
            cnt   <= HALF_CNT;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (!rx_sync) begin
              state   <= RX_DATA;
              cnt     <= FULL_CNT;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_sync, shreg[7:1]};
            cnt   <= FULL_CNT;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
            if (rx_sync) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              framing_error <= 1'b1;
              state         <= RX_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI front end: deserialises the serial stream and decodes Note On/Off for one
// channel into a single last-note-priority voice (note, velocity, gate).
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31_250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  input  logic [3:0] channel,
  output logic [6:0] MIDI_freq,
  output logic [6:0] volume,
  output logic       gate,
  output logic       note_valid,
  output logic       framing_error
);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  parser_state_t pstate;
  logic [3:0]    run_hi;
  logic          run_ignore;
  logic [6:0]    d1;

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .midi_rx      (midi_rx),
    .rx_byte      (rx_byte),
    .byte_valid   (byte_valid),
    .framing_error(framing_error)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate     <= P_WAIT_STATUS;
      run_hi     <= '0;
      run_ignore <= 1'b1;
      d1         <= '0;
      MIDI_freq  <= 7'd69;
      volume     <= '0;
      gate       <= 1'b0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (byte_valid) begin
        // Realtime bytes may interleave anywhere and must not disturb parsing.
        if (rx_byte >= SYSRT_MIN) begin
          pstate <= pstate;
        end else if (rx_byte >= SYSCOM_MIN) begin
          run_ignore <= 1'b1;
          pstate     <= P_WAIT_STATUS;
        end else if (rx_byte[7]) begin
          run_hi     <= rx_byte[7:4];
          run_ignore <= !(((rx_byte[7:4] == NOTE_OFF) || (rx_byte[7:4] == NOTE_ON)) &&
                          (rx_byte[3:0] == channel));
          pstate     <= P_WAIT_D1;
        end else begin
          case (pstate)
            P_WAIT_D1: begin
              if (!run_ignore) begin
                d1     <= rx_byte[6:0];
                pstate <= P_WAIT_D2;
              end
            end
            P_WAIT_D2: begin
              pstate <= P_WAIT_D1;
              if ((run_hi == NOTE_ON) && (rx_byte[6:0] != 7'd0)) begin
                MIDI_freq  <= d1;
                volume     <= rx_byte[6:0];
                gate       <= 1'b1;
                note_valid <= 1'b1;
              end else if (d1 == MIDI_freq) begin
                gate <= 1'b0;
              end
            end
            default: pstate <= pstate;
          endcase
        end
      end
    end
  end

endmodule
